// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: one car, NUM_FLOORS floors, latched hall/car calls served in SCAN order.
// Latency: a call latched on edge E is acted on from edge E+1 (door or motion); every output is registered.
// Backpressure: none; button pulses become sticky requests, presses at an open-door floor restart the dwell.
// Ports: clk, rst (synchronous, active-high); hall_up_btn/hall_down_btn/car_btn pulse inputs;
//   hall_up_lamp/hall_down_lamp/car_lamp latched requests; current_floor/floor_onehot car position;
//   moving/dir_up/door_open motor and door commands.
// Optional: define ELEV_ESTOP_EN to add the estop input (freezes travel/dwell timers, drops moving).
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] hall_up_btn,
    input  logic [NUM_FLOORS-1:0] hall_down_btn,
    input  logic [NUM_FLOORS-1:0] car_btn,
    output logic [NUM_FLOORS-1:0] hall_up_lamp,
    output logic [NUM_FLOORS-1:0] hall_down_lamp,
    output logic [NUM_FLOORS-1:0] car_lamp,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] floor_onehot,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open
);

    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    // No "up" call exists at the top floor and no "down" call at the lobby.
    localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t                  state_q;
    logic [FLOOR_W-1:0]      floor_q;
    logic [NUM_FLOORS-1:0]   onehot_q;
    logic                    dir_up_q, moving_q, door_q;
    logic [TCW-1:0]          tcnt_q;
    logic [DCW-1:0]          dcnt_q;
    logic [NUM_FLOORS-1:0]   up_req_q, dn_req_q, car_req_q;
    logic [NUM_FLOORS-1:0]   up_req_d, dn_req_d, car_req_d;

    logic                    hold;
`ifdef ELEV_ESTOP_EN
    assign hold = estop;
`else
    assign hold = 1'b0;
`endif

    // Any request strictly beyond floor f in the given direction.
    function automatic logic reqs_beyond(input logic [NUM_FLOORS-1:0] r,
                                         input logic [FLOOR_W-1:0] f, input logic up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (up ? (i > int'(f)) : (i < int'(f))) hit = hit | r[i];
        end
        return hit;
    endfunction

    logic [NUM_FLOORS-1:0] btn_up, btn_dn, all_q, nxt_onehot, clr_oh, absorb;
    logic [FLOOR_W-1:0]    nxt_floor;
    logic arrive, here_ahead, here_behind, here_serve, nxt_ahead, nxt_behind, nxt_stop;
    logic idle_to_door, move_to_door, clr_up, clr_dn, press_here;

    always_comb begin
        btn_up      = hall_up_btn & UP_MASK;
        btn_dn      = hall_down_btn & DN_MASK;
        all_q       = up_req_q | dn_req_q | car_req_q;
        nxt_floor   = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        nxt_onehot  = dir_up_q ? (onehot_q << 1) : (onehot_q >> 1);
        arrive      = (tcnt_q == TCW'(TRAVEL_CYCLES - 1));
        here_ahead  = reqs_beyond(all_q, floor_q, dir_up_q);
        here_behind = reqs_beyond(all_q, floor_q, !dir_up_q);
        nxt_ahead   = reqs_beyond(all_q, nxt_floor, dir_up_q);
        nxt_behind  = reqs_beyond(all_q, nxt_floor, !dir_up_q);
        // An opposite-direction hall call at this floor only opens the door when nothing
        // lies ahead; otherwise it waits for the return sweep instead of cycling the door.
        here_serve  = (|(car_req_q & onehot_q))
                    | (|((dir_up_q ? up_req_q : dn_req_q) & onehot_q))
                    | (!here_ahead & (|((up_req_q | dn_req_q) & onehot_q)));
        nxt_stop    = (|(car_req_q & nxt_onehot))
                    | (|((dir_up_q ? up_req_q : dn_req_q) & nxt_onehot))
                    | !nxt_ahead;
        idle_to_door = (state_q == S_IDLE) && !hold && here_serve;
        move_to_door = (state_q == S_MOVE) && !hold && arrive && nxt_stop;

        clr_oh = '0;
        clr_up = 1'b0;
        clr_dn = 1'b0;
        if (idle_to_door) begin
            clr_oh = onehot_q;
            clr_up = dir_up_q | !here_ahead;
            clr_dn = !dir_up_q | !here_ahead;
        end else if (move_to_door) begin
            clr_oh = nxt_onehot;
            clr_up = dir_up_q | !nxt_ahead;
            clr_dn = !dir_up_q | !nxt_ahead;
        end

        // Presses at the floor whose door is open are absorbed: they restart dwell, never latch.
        absorb     = (state_q == S_DOOR) ? onehot_q : '0;
        press_here = |((btn_up | btn_dn | car_btn) & onehot_q);
        up_req_d   = (up_req_q & ~(clr_up ? clr_oh : '0)) | (btn_up & ~absorb);
        dn_req_d   = (dn_req_q & ~(clr_dn ? clr_oh : '0)) | (btn_dn & ~absorb);
        car_req_d  = (car_req_q & ~clr_oh) | (car_btn & ~absorb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            onehot_q  <= NUM_FLOORS'(1);
            dir_up_q  <= 1'b1;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            up_req_q  <= '0;
            dn_req_q  <= '0;
            car_req_q <= '0;
        end else begin
            up_req_q  <= up_req_d;
            dn_req_q  <= dn_req_d;
            car_req_q <= car_req_d;
            case (state_q)
                S_IDLE: begin
                    if (!hold) begin
                        if (here_serve) begin
                            state_q <= S_DOOR;
                            door_q  <= 1'b1;
                            dcnt_q  <= '0;
                        end else if (here_ahead || here_behind) begin
                            state_q  <= S_MOVE;
                            moving_q <= 1'b1;
                            tcnt_q   <= '0;
                            if (!here_ahead) dir_up_q <= !dir_up_q;
                        end
                    end
                end
                S_MOVE: begin
                    if (hold) begin
                        moving_q <= 1'b0;
                    end else begin
                        moving_q <= 1'b1;
                        if (arrive) begin
                            floor_q  <= nxt_floor;
                            onehot_q <= nxt_onehot;
                            tcnt_q   <= '0;
                            if (nxt_stop) begin
                                state_q  <= S_DOOR;
                                moving_q <= 1'b0;
                                door_q   <= 1'b1;
                                dcnt_q   <= '0;
                                // End of sweep: turn round only if someone waits behind.
                                if (!nxt_ahead && nxt_behind) dir_up_q <= !dir_up_q;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TCW'(1);
                        end
                    end
                end
                S_DOOR: begin
                    if (!hold) begin
                        if (press_here) begin
                            dcnt_q <= '0;
                        end else if (dcnt_q == DCW'(DOOR_CYCLES - 1)) begin
                            state_q <= S_IDLE;
                            door_q  <= 1'b0;
                        end else begin
                            dcnt_q <= dcnt_q + DCW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    moving_q <= 1'b0;
                    door_q   <= 1'b0;
                end
            endcase
        end
    end

    assign hall_up_lamp   = up_req_q;
    assign hall_down_lamp = dn_req_q;
    assign car_lamp       = car_req_q;
    assign current_floor  = floor_q;
    assign floor_onehot   = onehot_q;
    assign moving         = moving_q;
    assign dir_up         = dir_up_q;
    assign door_open      = door_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl (4 floors, 4-cycle travel, 3-cycle dwell): directed scenarios
// with timing checked against fixed expectations, then random calls checked against a
// request-list reference model of the car.
module tb_elevator_scan_ctrl;
    localparam int NF = 4;
    localparam int TC = 4;
    localparam int DC = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_MOVE = 1;
    localparam int PH_DOOR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] hall_up_btn = '0, hall_down_btn = '0, car_btn = '0;
    logic [NF-1:0] hall_up_lamp, hall_down_lamp, car_lamp, floor_onehot;
    logic [1:0]    current_floor;
    logic          moving, dir_up, door_open;
`ifdef ELEV_ESTOP_EN
    logic          estop = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
`ifdef ELEV_ESTOP_EN
        .estop(estop),
`endif
        .hall_up_btn(hall_up_btn), .hall_down_btn(hall_down_btn), .car_btn(car_btn),
        .hall_up_lamp(hall_up_lamp), .hall_down_lamp(hall_down_lamp), .car_lamp(car_lamp),
        .current_floor(current_floor), .floor_onehot(floor_onehot),
        .moving(moving), .dir_up(dir_up), .door_open(door_open)
    );

    // ---------------- reference model: pending-call lists plus a countdown ----------------
    bit m_up [NF];
    bit m_dn [NF];
    bit m_car [NF];
    int m_floor, m_phase, m_left;
    bit m_dir;

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin
            m_up[f] = 0; m_dn[f] = 0; m_car[f] = 0;
        end
        m_floor = 0; m_phase = PH_IDLE; m_left = 0; m_dir = 1;
    endtask

    function automatic bit m_beyond(int g, bit up);
        for (int f = 0; f < NF; f++)
            if ((m_up[f] || m_dn[f] || m_car[f]) && (up ? (f > g) : (f < g))) return 1;
        return 0;
    endfunction

    function automatic bit m_hall_dir(int g, bit up);
        return up ? m_up[g] : m_dn[g];
    endfunction

    function automatic bit m_wants(int g, bit up);
        return m_car[g] || m_hall_dir(g, up) || (!m_beyond(g, up) && (m_up[g] || m_dn[g]));
    endfunction

    task automatic m_serve(int g);
        bit nb;
        nb = m_beyond(g, m_dir);
        m_car[g] = 0;
        if (m_dir || !nb) m_up[g] = 0;
        if (!m_dir || !nb) m_dn[g] = 0;
    endtask

    task automatic model_step(input logic [NF-1:0] bu, bd, bc, input logic r);
        int  of, oph, g;
        bit  press, flip;
        if (r) begin
            model_reset();
        end else begin
            of = m_floor; oph = m_phase;
            press = 0;
            for (int f = 0; f < NF; f++)
                if (f == of && ((bu[f] && f != NF-1) || (bd[f] && f != 0) || bc[f])) press = 1;
            case (m_phase)
                PH_IDLE: begin
                    if (m_wants(of, m_dir)) begin
                        m_serve(of); m_phase = PH_DOOR; m_left = DC;
                    end else if (m_beyond(of, m_dir)) begin
                        m_phase = PH_MOVE; m_left = TC;
                    end else if (m_beyond(of, !m_dir)) begin
                        m_dir = !m_dir; m_phase = PH_MOVE; m_left = TC;
                    end
                end
                PH_MOVE: begin
                    m_left--;
                    if (m_left == 0) begin
                        g = m_dir ? of + 1 : of - 1;
                        m_floor = g;
                        if (m_car[g] || m_hall_dir(g, m_dir) || !m_beyond(g, m_dir)) begin
                            flip = !m_beyond(g, m_dir) && m_beyond(g, !m_dir);
                            m_serve(g);
                            if (flip) m_dir = !m_dir;
                            m_phase = PH_DOOR; m_left = DC;
                        end else begin
                            m_left = TC;
                        end
                    end
                end
                default: begin
                    if (press) m_left = DC;
                    else begin
                        m_left--;
                        if (m_left == 0) m_phase = PH_IDLE;
                    end
                end
            endcase
            for (int f = 0; f < NF; f++) begin
                if (!(oph == PH_DOOR && f == of)) begin
                    if (bu[f] && f != NF-1) m_up[f] = 1;
                    if (bd[f] && f != 0) m_dn[f] = 1;
                    if (bc[f]) m_car[f] = 1;
                end
            end
        end
    endtask

    function automatic logic [NF-1:0] pack(bit a [NF]);
        logic [NF-1:0] v;
        for (int f = 0; f < NF; f++) v[f] = a[f];
        return v;
    endfunction

    // One clock: inputs driven at the falling edge, sampled at the rising edge; returns at
    // the next falling edge so outputs are read away from the active edge.
    task automatic tick(input logic [NF-1:0] bu, bd, bc, input logic r);
        hall_up_btn = bu; hall_down_btn = bd; car_btn = bc; rst = r;
        @(posedge clk);
        model_step(bu, bd, bc, r);
        @(negedge clk);
        hall_up_btn = '0; hall_down_btn = '0; car_btn = '0; rst = 1'b0;
    endtask

    task automatic do_reset();
        tick('0, '0, '0, 1'b1);
        tick('0, '0, '0, 1'b1);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset();
        tests++; if (current_floor !== 2'd0) begin fails++; $display("FAIL reset_floor: got %0d want 0", current_floor); end
        tests++; if (floor_onehot !== 4'b0001) begin fails++; $display("FAIL reset_onehot: got %b want 0001", floor_onehot); end
        tests++; if (dir_up !== 1'b1) begin fails++; $display("FAIL reset_dir: got %b want 1", dir_up); end
        tests++; if (moving !== 1'b0 || door_open !== 1'b0) begin fails++; $display("FAIL reset_motion: moving %b door %b want 0 0", moving, door_open); end
        tests++; if ({hall_up_lamp, hall_down_lamp, car_lamp} !== 12'h0) begin fails++; $display("FAIL reset_lamps: got %h want 000", {hall_up_lamp, hall_down_lamp, car_lamp}); end
        tick('0, '0, '0, 1'b0);
        tests++; if (moving !== 1'b0 || door_open !== 1'b0) begin fails++; $display("FAIL reset_idle_stays: moving %b door %b want 0 0", moving, door_open); end
    endtask

    task automatic test_car_trip();
        logic [1:0] ef; logic em, ed; logic [NF-1:0] el;
        do_reset();
        tick('0, '0, 4'b0100, 1'b0);
        tests++; if (car_lamp !== 4'b0100 || moving !== 1'b0) begin fails++; $display("FAIL trip_latch: lamp %b moving %b want 0100 0", car_lamp, moving); end
        for (int c = 1; c <= 12; c++) begin
            tick('0, '0, '0, 1'b0);
            ef = (c < 5) ? 2'd0 : (c < 9) ? 2'd1 : 2'd2;
            em = (c <= 8);
            ed = (c >= 9 && c <= 11);
            el = (c < 9) ? 4'b0100 : 4'b0000;
            tests++; if (current_floor !== ef) begin fails++; $display("FAIL trip_floor c%0d: got %0d want %0d", c, current_floor, ef); end
            tests++; if (moving !== em) begin fails++; $display("FAIL trip_moving c%0d: got %b want %b", c, moving, em); end
            tests++; if (door_open !== ed) begin fails++; $display("FAIL trip_door c%0d: got %b want %b", c, door_open, ed); end
            tests++; if (car_lamp !== el) begin fails++; $display("FAIL trip_lamp c%0d: got %b want %b", c, car_lamp, el); end
        end
    endtask

    task automatic test_door_dwell();
        logic ed;
        do_reset();
        tick(4'b0001, '0, '0, 1'b0);
        tests++; if (hall_up_lamp !== 4'b0001 || door_open !== 1'b0) begin fails++; $display("FAIL dwell_latch: lamp %b door %b want 0001 0", hall_up_lamp, door_open); end
        for (int c = 1; c <= 6; c++) begin
            tick((c == 2) ? 4'b0001 : 4'b0000, '0, '0, 1'b0);
            ed = (c <= 4);
            tests++; if (door_open !== ed) begin fails++; $display("FAIL dwell_door c%0d: got %b want %b", c, door_open, ed); end
            tests++; if (moving !== 1'b0 || current_floor !== 2'd0) begin fails++; $display("FAIL dwell_still c%0d: moving %b floor %0d want 0 0", c, moving, current_floor); end
            tests++; if (hall_up_lamp !== 4'b0000) begin fails++; $display("FAIL dwell_absorb c%0d: got %b want 0000", c, hall_up_lamp); end
        end
    endtask

    task automatic test_intermediate_stop();
        logic [1:0] ef; logic em, ed; logic [NF-1:0] eu, ec;
        do_reset();
        tick('0, '0, 4'b1000, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            tick((c == 2) ? 4'b0010 : 4'b0000, '0, '0, 1'b0);
            ef = (c < 5) ? 2'd0 : (c < 13) ? 2'd1 : (c < 17) ? 2'd2 : 2'd3;
            em = (c <= 4) || (c >= 9 && c <= 16);
            ed = (c >= 5 && c <= 7) || (c >= 17 && c <= 19);
            eu = (c >= 2 && c <= 4) ? 4'b0010 : 4'b0000;
            ec = (c < 17) ? 4'b1000 : 4'b0000;
            tests++; if (current_floor !== ef) begin fails++; $display("FAIL mid_floor c%0d: got %0d want %0d", c, current_floor, ef); end
            tests++; if (moving !== em) begin fails++; $display("FAIL mid_moving c%0d: got %b want %b", c, moving, em); end
            tests++; if (door_open !== ed) begin fails++; $display("FAIL mid_door c%0d: got %b want %b", c, door_open, ed); end
            tests++; if (hall_up_lamp !== eu || car_lamp !== ec) begin fails++; $display("FAIL mid_lamps c%0d: up %b car %b want %b %b", c, hall_up_lamp, car_lamp, eu, ec); end
        end
    endtask

    task automatic test_scan_pass();
        logic [1:0] ef; logic em, ed, edir; logic [NF-1:0] edn, ec;
        do_reset();
        tick('0, 4'b0010, 4'b1000, 1'b0);
        for (int c = 1; c <= 26; c++) begin
            tick('0, '0, '0, 1'b0);
            ef = (c < 5) ? 2'd0 : (c < 9) ? 2'd1 : (c < 13) ? 2'd2 : (c < 21) ? 2'd3 : (c < 25) ? 2'd2 : 2'd1;
            em = (c <= 12) || (c >= 17 && c <= 24);
            ed = (c >= 13 && c <= 15) || (c >= 25);
            edir = (c < 13);
            edn = (c < 25) ? 4'b0010 : 4'b0000;
            ec = (c < 13) ? 4'b1000 : 4'b0000;
            tests++; if (current_floor !== ef) begin fails++; $display("FAIL scan_floor c%0d: got %0d want %0d", c, current_floor, ef); end
            tests++; if (moving !== em || door_open !== ed) begin fails++; $display("FAIL scan_motion c%0d: moving %b door %b want %b %b", c, moving, door_open, em, ed); end
            tests++; if (dir_up !== edir) begin fails++; $display("FAIL scan_dir c%0d: got %b want %b", c, dir_up, edir); end
            tests++; if (hall_down_lamp !== edn || car_lamp !== ec) begin fails++; $display("FAIL scan_lamps c%0d: down %b car %b want %b %b", c, hall_down_lamp, car_lamp, edn, ec); end
        end
    endtask

    task automatic test_reset_mid_travel();
        do_reset();
        tick('0, '0, 4'b1000, 1'b0);
        for (int c = 1; c <= 6; c++) tick('0, (c == 2) ? 4'b0100 : 4'b0000, '0, 1'b0);
        tests++; if (current_floor !== 2'd1 || moving !== 1'b1 || hall_down_lamp !== 4'b0100) begin fails++; $display("FAIL rstmid_pre: floor %0d moving %b down %b want 1 1 0100", current_floor, moving, hall_down_lamp); end
        tick('0, '0, '0, 1'b1);
        tests++; if (current_floor !== 2'd0 || floor_onehot !== 4'b0001) begin fails++; $display("FAIL rstmid_floor: floor %0d onehot %b want 0 0001", current_floor, floor_onehot); end
        tests++; if (moving !== 1'b0 || door_open !== 1'b0 || dir_up !== 1'b1) begin fails++; $display("FAIL rstmid_ctrl: moving %b door %b dir %b want 0 0 1", moving, door_open, dir_up); end
        tests++; if ({hall_up_lamp, hall_down_lamp, car_lamp} !== 12'h0) begin fails++; $display("FAIL rstmid_lamps: got %h want 000", {hall_up_lamp, hall_down_lamp, car_lamp}); end
        tick('0, '0, '0, 1'b0);
        tests++; if (moving !== 1'b0 || door_open !== 1'b0) begin fails++; $display("FAIL rstmid_after: moving %b door %b want 0 0", moving, door_open); end
    endtask

    task automatic test_random();
        logic [NF-1:0] bu, bd, bc, oh;
        logic          r;
        logic [7:0]    got [8];
        logic [7:0]    want [8];
        string         nm [8];
        nm = '{"floor", "onehot", "moving", "dir_up", "door", "up_lamp", "down_lamp", "car_lamp"};
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int f = 0; f < NF; f++) begin
                bu[f] = ($urandom_range(0, 23) == 0);
                bd[f] = ($urandom_range(0, 23) == 0);
                bc[f] = ($urandom_range(0, 23) == 0);
            end
            r = ($urandom_range(0, 399) == 0);
            tick(bu, bd, bc, r);
            oh = 4'b0001 << m_floor;
            got[0] = 8'(current_floor);  want[0] = 8'(m_floor);
            got[1] = 8'(floor_onehot);   want[1] = 8'(oh);
            got[2] = 8'(moving);         want[2] = 8'(m_phase == PH_MOVE);
            got[3] = 8'(dir_up);         want[3] = 8'(m_dir);
            got[4] = 8'(door_open);      want[4] = 8'(m_phase == PH_DOOR);
            got[5] = 8'(hall_up_lamp);   want[5] = 8'(pack(m_up));
            got[6] = 8'(hall_down_lamp); want[6] = 8'(pack(m_dn));
            got[7] = 8'(car_lamp);       want[7] = 8'(pack(m_car));
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (got[k] !== want[k]) begin
                    fails++;
                    $display("FAIL rand_%s cyc %0d: got %h want %h", nm[k], cyc, got[k], want[k]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_car_trip();
        test_door_dwell();
        test_intermediate_stop();
        test_scan_pass();
        test_reset_mid_travel();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
